hazard_stall_ctrl: RTL and testbench

//  Pipeline control for the 5-stage CPU. It drives the hold, bubble and flush inputs of the
//  PC, IF_ID and ID_EX registers. It detects load-use hazards between the ID and EX stages.
//  It freezes the whole pipeline while a multi-cycle data-memory access completes in MEM.
//  It flushes IF on a taken branch resolved in ID, and keeps saturating stall/flush counters.

---
 rtl/hazard_stall_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, IF flush on taken branch,
// whole-pipeline freeze during multi-cycle data-memory accesses, saturating perf counters.
module hazard_stall_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic [4:0]       ID_Rs1_i,
  input  logic [4:0]       ID_Rs2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_Rd_i,
  input  logic             Branch_taken_i,
  input  logic             MEM_Access_i,
  output logic             PCWrite_o,
  output logic             IF_ID_Write_o,
  output logic             Bubble_o,
  output logic             IF_Flush_o,
  output logic             Freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             state_o
);

  localparam int              WC_W    = $clog2(MEM_LAT) + 1;
  localparam logic [WC_W-1:0] WC_LOAD = WC_W'(MEM_LAT - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
  localparam bit              MULTI   = (MEM_LAT > 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            lu;
  logic            frz;

  assign lu = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
              ((EX_Rd_i == ID_Rs1_i) || (EX_Rd_i == ID_Rs2_i));

  // The accepting RUN cycle is itself the first frozen cycle; the last MEM_WAIT cycle is not.
  assign frz = ((state == RUN) && MEM_Access_i && MULTI) ||
               ((state == MEM_WAIT) && (wait_cnt > WC_ONE));

  assign state_o = state;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (MEM_Access_i && MULTI) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WC_LOAD;
        end
      end
      MEM_WAIT: begin
        if (wait_cnt > WC_ONE) begin
          wait_cnt_nxt = wait_cnt - WC_ONE;
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Priority: freeze over load-use over flush; everything low while reset is held.
  always_comb begin
    PCWrite_o     = 1'b0;
    IF_ID_Write_o = 1'b0;
    Bubble_o      = 1'b0;
    IF_Flush_o    = 1'b0;
    Freeze_o      = 1'b0;
    if (start_i) begin
      if (frz) begin
        Freeze_o = 1'b1;
      end else if (lu) begin
        Bubble_o = 1'b1;
      end else begin
        PCWrite_o     = 1'b1;
        IF_ID_Write_o = 1'b1;
        IF_Flush_o    = Branch_taken_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((frz || lu) && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (IF_Flush_o && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three configurations share stimulus and are checked
// against an access-window reference model, plus a vector table and corner sequences.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       start;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, br_taken, mem_access;

  typedef struct packed {
    logic        pcw;
    logic        ifidw;
    logic        bub;
    logic        flush;
    logic        frz;
    logic        st;
    logic [15:0] stall;
    logic [15:0] fcnt;
  } obs_t;

  obs_t obs [3];

  logic        pcw0, ifidw0, bub0, fl0, frz0, st0;
  logic        pcw1, ifidw1, bub1, fl1, frz1, st1;
  logic        pcw2, ifidw2, bub2, fl2, frz2, st2;
  logic [15:0] stall0, fcnt0, stall1, fcnt1;
  logic [1:0]  stall2, fcnt2;

  hazard_stall_ctrl #(.MEM_LAT(1), .CNT_W(16)) dut0 (
    .clk_i(clk), .start_i(start), .ID_Rs1_i(id_rs1), .ID_Rs2_i(id_rs2),
    .EX_MemRead_i(ex_mem_read), .EX_Rd_i(ex_rd), .Branch_taken_i(br_taken),
    .MEM_Access_i(mem_access), .PCWrite_o(pcw0), .IF_ID_Write_o(ifidw0),
    .Bubble_o(bub0), .IF_Flush_o(fl0), .Freeze_o(frz0), .stall_cnt_o(stall0),
    .flush_cnt_o(fcnt0), .state_o(st0));

  hazard_stall_ctrl #(.MEM_LAT(3), .CNT_W(16)) dut1 (
    .clk_i(clk), .start_i(start), .ID_Rs1_i(id_rs1), .ID_Rs2_i(id_rs2),
    .EX_MemRead_i(ex_mem_read), .EX_Rd_i(ex_rd), .Branch_taken_i(br_taken),
    .MEM_Access_i(mem_access), .PCWrite_o(pcw1), .IF_ID_Write_o(ifidw1),
    .Bubble_o(bub1), .IF_Flush_o(fl1), .Freeze_o(frz1), .stall_cnt_o(stall1),
    .flush_cnt_o(fcnt1), .state_o(st1));

  hazard_stall_ctrl #(.MEM_LAT(4), .CNT_W(2)) dut2 (
    .clk_i(clk), .start_i(start), .ID_Rs1_i(id_rs1), .ID_Rs2_i(id_rs2),
    .EX_MemRead_i(ex_mem_read), .EX_Rd_i(ex_rd), .Branch_taken_i(br_taken),
    .MEM_Access_i(mem_access), .PCWrite_o(pcw2), .IF_ID_Write_o(ifidw2),
    .Bubble_o(bub2), .IF_Flush_o(fl2), .Freeze_o(frz2), .stall_cnt_o(stall2),
    .flush_cnt_o(fcnt2), .state_o(st2));

  assign obs[0] = {pcw0, ifidw0, bub0, fl0, frz0, st0, stall0, fcnt0};
  assign obs[1] = {pcw1, ifidw1, bub1, fl1, frz1, st1, stall1, fcnt1};
  assign obs[2] = {pcw2, ifidw2, bub2, fl2, frz2, st2, 14'd0, stall2, 14'd0, fcnt2};

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // An accepted access occupies MEM_LAT cycles starting at its accept cycle; the
  // first MEM_LAT-1 of them are frozen and no new access is accepted inside it.
  int lat [3] = '{1, 3, 4};
  int cw  [3] = '{16, 16, 2};
  int acc_start [3];
  int m_stall [3];
  int m_flush [3];
  int cyc;

  int n_checks;
  int n_fail;

  function automatic bit lu_now();
    return ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  endfunction

  function automatic bit in_window(input int i);
    return (acc_start[i] >= 0) && (cyc <= acc_start[i] + lat[i] - 1);
  endfunction

  function automatic bit started_now(input int i);
    return !in_window(i) && mem_access && (lat[i] > 1);
  endfunction

  function automatic bit frozen_now(input int i);
    if (started_now(i)) return 1'b1;
    return in_window(i) && ((cyc - acc_start[i]) < (lat[i] - 1));
  endfunction

  function automatic obs_t exp_of(input int i);
    obs_t e;
    e = '0;
    e.stall = 16'(m_stall[i]);
    e.fcnt  = 16'(m_flush[i]);
    if (!start) return e;
    e.st = in_window(i);
    if (frozen_now(i)) begin
      e.frz = 1'b1;
    end else if (lu_now()) begin
      e.bub = 1'b1;
    end else begin
      e.pcw   = 1'b1;
      e.ifidw = 1'b1;
      e.flush = br_taken;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      acc_start[i] = -1000;
      m_stall[i]   = 0;
      m_flush[i]   = 0;
    end
  endtask

  task automatic model_tick();
    obs_t e;
    int   maxv;
    if (start) begin
      for (int i = 0; i < 3; i++) begin
        e    = exp_of(i);
        maxv = (1 << cw[i]) - 1;
        if ((frozen_now(i) || lu_now()) && (m_stall[i] < maxv)) m_stall[i]++;
        if (e.flush && (m_flush[i] < maxv)) m_flush[i]++;
        if (started_now(i)) acc_start[i] = cyc;
      end
    end
    cyc++;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d at %0t: got %0d expected %0d", name, i, $time, act, exp);
    end
  endtask

  task automatic check_model();
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      e = exp_of(i);
      chk("pcwrite",   i, 32'(obs[i].pcw),   32'(e.pcw));
      chk("ifid_write", i, 32'(obs[i].ifidw), 32'(e.ifidw));
      chk("bubble",    i, 32'(obs[i].bub),   32'(e.bub));
      chk("if_flush",  i, 32'(obs[i].flush), 32'(e.flush));
      chk("freeze",    i, 32'(obs[i].frz),   32'(e.frz));
      chk("state",     i, 32'(obs[i].st),    32'(e.st));
      chk("stall_cnt", i, 32'(obs[i].stall), 32'(e.stall));
      chk("flush_cnt", i, 32'(obs[i].fcnt),  32'(e.fcnt));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic acc);
    id_rs1      = rs1;
    id_rs2      = rs2;
    ex_rd       = rd;
    ex_mem_read = mr;
    br_taken    = br;
    mem_access  = acc;
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic adv();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic mr, input logic br, input logic acc);
    drive(rs1, rs2, rd, mr, br, acc);
    sample();
    adv();
  endtask

  task automatic do_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 start = 1'b0;
    model_reset();
    #1 check_model();
    @(posedge clk);
    @(negedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       mr, br;
    logic       e_pcw, e_bub, e_flush;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{5'd3,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{5'd0,  5'd4,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{5'd5,  5'd5,  5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{5'd1,  5'd2,  5'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{5'd7,  5'd2,  5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  end

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    start    = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #3 check_model();
    @(negedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;

    // table vectors, all configurations idle in RUN
    for (int k = 0; k < 9; k++) begin
      drive(vecs[k].rs1, vecs[k].rs2, vecs[k].rd, vecs[k].mr, vecs[k].br, 1'b0);
      sample();
      for (int i = 0; i < 3; i++) begin
        chk("vec_pcwrite", i, 32'(obs[i].pcw),   32'(vecs[k].e_pcw));
        chk("vec_ifid",    i, 32'(obs[i].ifidw), 32'(vecs[k].e_pcw));
        chk("vec_bubble",  i, 32'(obs[i].bub),   32'(vecs[k].e_bub));
        chk("vec_flush",   i, 32'(obs[i].flush), 32'(vecs[k].e_flush));
        chk("vec_freeze",  i, 32'(obs[i].frz),   32'd0);
      end
      adv();
    end

    // load-use single stall
    do_reset();
    drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    sample();
    chk("lu_pcwrite", 1, 32'(pcw1), 32'd0);
    chk("lu_bubble",  1, 32'(bub1), 32'd1);
    adv();
    drive(5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0);
    sample();
    chk("lu_after_pcwrite", 1, 32'(pcw1), 32'd1);
    chk("lu_after_stall",   1, 32'(stall1), 32'd1);
    adv();

    // MEM_LAT=3 freeze lasts exactly two cycles
    do_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    sample();
    chk("frz_c0", 1, 32'(frz1), 32'd1);
    adv();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("frz_c1", 1, 32'(frz1), 32'd1);
    adv();
    sample();
    chk("frz_c2", 1, 32'(frz1), 32'd0);
    chk("frz_c2_pcw", 1, 32'(pcw1), 32'd1);
    chk("frz_stall", 1, 32'(stall1), 32'd2);
    adv();
    sample();
    chk("frz_run", 1, 32'(st1), 32'd0);
    adv();

    // freeze masks load-use and branch, then load-use, then flush
    do_reset();
    drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
    sample();
    chk("mix_c0_frz", 1, 32'(frz1), 32'd1);
    chk("mix_c0_bub", 1, 32'(bub1), 32'd0);
    chk("mix_c0_fl",  1, 32'(fl1),  32'd0);
    adv();
    drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    sample();
    chk("mix_c1_bub", 1, 32'(bub1), 32'd0);
    chk("mix_c1_fl",  1, 32'(fl1),  32'd0);
    adv();
    sample();
    chk("mix_c2_bub", 1, 32'(bub1), 32'd1);
    chk("mix_c2_pcw", 1, 32'(pcw1), 32'd0);
    chk("mix_c2_fl",  1, 32'(fl1),  32'd0);
    adv();
    drive(5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0);
    sample();
    chk("mix_c3_fl",  1, 32'(fl1),  32'd1);
    chk("mix_c3_pcw", 1, 32'(pcw1), 32'd1);
    adv();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("mix_flush_cnt", 1, 32'(fcnt1), 32'd1);
    chk("mix_stall_cnt", 1, 32'(stall1), 32'd3);
    adv();

    // reset in the second MEM_WAIT cycle of a MEM_LAT=4 access
    do_reset();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2 start = 1'b0;
    model_reset();
    #1;
    chk("rst_pcw",   2, 32'(pcw2),   32'd0);
    chk("rst_ifid",  2, 32'(ifidw2), 32'd0);
    chk("rst_frz",   2, 32'(frz2),   32'd0);
    chk("rst_stall", 2, 32'(stall2), 32'd0);
    chk("rst_state", 2, 32'(st2),    32'd0);
    check_model();
    @(posedge clk);
    @(negedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    sample();
    chk("rel_pcw",   2, 32'(pcw2), 32'd1);
    chk("rel_frz",   2, 32'(frz2), 32'd0);
    chk("rel_state", 2, 32'(st2),  32'd0);
    adv();

    // CNT_W=2 stall counter saturates
    do_reset();
    for (int k = 0; k < 5; k++) step(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("sat_stall", 2, 32'(stall2), 32'd3);
    adv();

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
